mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 16, address width in bits.
REQ-002 Parameter: DATA_W, 16, data word width in bits.
REQ-003 Parameter: STARVE_MAX, 4, consecutive data grants allowed while fetch waits (legal range 1..15).
REQ-004 clock  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 i_req  input  1  fetch request; held high with i_addr stable until i_done.
REQ-007 i_addr  input  ADDR_W  fetch byte address; fetch accesses are always whole words.
REQ-008 i_done  output  1  one-cycle fetch completion pulse.
REQ-009 i_rdata  output  DATA_W  fetched word; valid only while i_done is high.
REQ-010 i_err  output  1  odd-address error; valid only while i_done is high.
REQ-011 d_req, d_we, d_byte  input  1 each  data request, write enable and byte access; held stable until d_done.
REQ-012 d_addr, d_wdata  input  ADDR_W, DATA_W  data byte address and write data.
REQ-013 d_done, d_err  output  1 each  data completion pulse and odd-address error.
REQ-014 d_rdata  output  DATA_W  data read value; valid only while d_done is high.
REQ-015 mem_req, mem_we, mem_byte  output  1 each  memory request, write enable and byte access.
REQ-016 mem_addr, mem_wdata  output  ADDR_W, DATA_W  memory address and write data.
REQ-017 mem_ready, mem_rdata  input  1, DATA_W  memory completion and read data; sampled only while mem_req is high.
REQ-018 owner  output  2  current owner: 00 none, 01 fetch, 10 data.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, BUSY and RESP.
REQ-020 In IDLE with neither request high, the FSM SHALL remain in IDLE and owner SHALL be 00.
REQ-021 In IDLE with only one request high, that requester SHALL be granted.
REQ-022 In IDLE with both requests high and starve_cnt < STARVE_MAX, data SHALL be granted; otherwise fetch SHALL be granted.
REQ-023 starve_cnt SHALL increment on a data grant while i_req is high.
REQ-024 starve_cnt SHALL clear on any fetch grant, and on a data grant while i_req is low.
REQ-025 starve_cnt SHALL saturate at STARVE_MAX.
REQ-026 On a grant, the FSM SHALL move IDLE->BUSY, latch the requester's address, data and controls, and drive mem_req high from the next cycle.
REQ-027 In BUSY, all mem_* outputs SHALL stay stable until the cycle in which mem_ready is high.
REQ-028 On mem_ready in BUSY, the FSM SHALL register mem_rdata, drop mem_req and move to RESP.
REQ-029 In RESP, the owner's done SHALL be high for exactly one cycle with rdata valid, then the FSM SHALL return to IDLE.
REQ-030 No arbitration SHALL occur in RESP; a requester may present its next request from the cycle after done.
REQ-031 Minimum latency from req sampled in IDLE to done SHALL be 2 cycles (grant, mem_ready in the first BUSY cycle, then RESP).
REQ-032 For fetch grants, mem_we and mem_byte SHALL be driven 0.
REQ-033 i_done and d_done SHALL never be high in the same cycle.
REQ-034 mem_req SHALL be high only in BUSY.
REQ-035 owner SHALL hold the granted requester's code throughout BUSY and RESP.

Reset
REQ-036 While reset is high, the FSM SHALL be IDLE, starve_cnt 0, and all outputs 0.
REQ-037 Reset asserted mid-transaction SHALL abandon the transaction: mem_req low on the next edge and no done pulse issued.

Configuration
REQ-038 With ODD_ADDR_TRAP_EN defined, a word access (fetch, or data with d_byte=0) to an odd address SHALL bypass memory: IDLE->RESP directly, done with err=1 and rdata 0, starve_cnt updated as for a normal grant.
REQ-039 Without ODD_ADDR_TRAP_EN, word-access addresses SHALL have bit 0 forced to 0 on mem_addr, and err outputs SHALL be tied 0.

Verification
REQ-040 Single fetch, i_addr=16'o1000, mem_ready one cycle after mem_req, mem_rdata=16'o012700 -> i_done 3 cycles after i_req with i_rdata=16'o012700.
REQ-041 Both requests held continuously, STARVE_MAX=4 -> grant order D,D,D,D,I repeating, with no fetch waiting more than 4 data transactions.
REQ-042 d_we=1, d_byte=1, d_addr=16'o1001, d_wdata=16'h00A5 -> mem_we=1, mem_byte=1, mem_addr=16'o1001, d_done=1, d_err=0.
REQ-043 Word fetch to i_addr=16'o1003 with ODD_ADDR_TRAP_EN -> i_done with i_err=1, and mem_req never asserted; without the macro -> mem_addr=16'o1002 and i_err=0.
REQ-044 Reset asserted in BUSY while mem_ready is held low for 5 cycles -> mem_req=0, owner=00, and no done pulse; a subsequent request completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) memory arbiter with bounded fetch starvation.
// Optional feature: define ODD_ADDR_TRAP_EN to trap odd-address word accesses with err instead of aligning them.
module mem_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int STARVE_MAX = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_done,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_err,
   input  logic              d_req,
   input  logic              d_we,
   input  logic              d_byte,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_done,
   output logic              d_err,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic              mem_byte,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        owner
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   localparam logic [1:0] OwnNone  = 2'b00;
   localparam logic [1:0] OwnFetch = 2'b01;
   localparam logic [1:0] OwnData  = 2'b10;
   localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

   state_t            state_q, state_d;
   logic [1:0]        owner_q, owner_d;
   logic [3:0]        starveCnt_q, starveCnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              we_q, we_d;
   logic              byte_q, byte_d;
`ifdef ODD_ADDR_TRAP_EN
   logic              err_q, err_d;
`endif

   logic              grantData, grantFetch, wordAccess;
   logic [ADDR_W-1:0] reqAddr;
   logic              busy, resp;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         owner_q     <= OwnNone;
         starveCnt_q <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         we_q        <= 1'b0;
         byte_q      <= 1'b0;
`ifdef ODD_ADDR_TRAP_EN
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         starveCnt_q <= starveCnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         we_q        <= we_d;
         byte_q      <= byte_d;
`ifdef ODD_ADDR_TRAP_EN
         err_q       <= err_d;
`endif
      end
   end

   // Data wins ties until fetch has been passed over StarveMax times in a row.
   always_comb begin
      grantData  = d_req && (!i_req || (starveCnt_q < StarveMax));
      grantFetch = i_req && !grantData;
      wordAccess = grantFetch || !d_byte;
      reqAddr    = grantFetch ? i_addr : d_addr;

      state_d     = state_q;
      owner_d     = owner_q;
      starveCnt_d = starveCnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      we_d        = we_q;
      byte_d      = byte_q;
`ifdef ODD_ADDR_TRAP_EN
      err_d       = err_q;
`endif

      case (state_q)
         IDLE: begin
            if (grantData || grantFetch) begin
               state_d = BUSY;
               owner_d = grantFetch ? OwnFetch : OwnData;
               we_d    = grantData && d_we;
               byte_d  = grantData && d_byte;
               wdata_d = grantData ? d_wdata : '0;
               if (grantFetch || !i_req) begin
                  starveCnt_d = '0;
               end else if (starveCnt_q < StarveMax) begin
                  starveCnt_d = starveCnt_q + 4'd1;
               end
`ifdef ODD_ADDR_TRAP_EN
               addr_d = reqAddr;
               err_d  = 1'b0;
               // Misaligned word access never reaches memory.
               if (wordAccess && reqAddr[0]) begin
                  state_d = RESP;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end
`else
               addr_d = wordAccess ? {reqAddr[ADDR_W-1:1], 1'b0} : reqAddr;
`endif
            end
         end
         BUSY: begin
            if (mem_ready) begin
               rdata_d = mem_rdata;
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
            owner_d = OwnNone;
         end
         default: begin
            state_d = IDLE;
            owner_d = OwnNone;
         end
      endcase
   end

   // Outputs decode straight from registered state so they are glitch-free.
   always_comb begin
      busy      = (state_q == BUSY);
      resp      = (state_q == RESP);
      mem_req   = busy;
      mem_we    = busy && we_q;
      mem_byte  = busy && byte_q;
      mem_addr  = busy ? addr_q : '0;
      mem_wdata = busy ? wdata_q : '0;
      owner     = owner_q;
      i_done    = resp && (owner_q == OwnFetch);
      d_done    = resp && (owner_q == OwnData);
      i_rdata   = i_done ? rdata_q : '0;
      d_rdata   = d_done ? rdata_q : '0;
`ifdef ODD_ADDR_TRAP_EN
      i_err     = i_done && err_q;
      d_err     = d_done && err_q;
`else
      i_err     = 1'b0;
      d_err     = 1'b0;
`endif
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; adapts the odd-address case to ODD_ADDR_TRAP_EN.
module tb_mem_arbiter;

   logic        clock;
   logic        reset;
   logic        i_req;
   logic [15:0] i_addr;
   logic        i_done;
   logic [15:0] i_rdata;
   logic        i_err;
   logic        d_req, d_we, d_byte;
   logic [15:0] d_addr, d_wdata;
   logic        d_done, d_err;
   logic [15:0] d_rdata;
   logic        mem_req, mem_we, mem_byte;
   logic [15:0] mem_addr, mem_wdata;
   logic        mem_ready;
   logic [15:0] mem_rdata;
   logic [1:0]  owner;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(4)) dut (
      .clock(clock), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_err(i_err),
      .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .owner(owner)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one clock edge and settle before sampling or changing inputs.
   task automatic applyStimulus();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      logic [1:0] expOwner;
      reset = 1'b1; i_req = 1'b0; i_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_byte = 1'b0; d_addr = '0; d_wdata = '0;
      mem_ready = 1'b0; mem_rdata = '0;
      applyStimulus();
      applyStimulus();
      checkOutput("rst_owner", 32'(owner), 32'd0);
      checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
      checkOutput("rst_i_done", 32'(i_done), 32'd0);
      checkOutput("rst_d_done", 32'(d_done), 32'd0);
      checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
      reset = 1'b0;
      applyStimulus();
      checkOutput("idle_owner", 32'(owner), 32'd0);
      checkOutput("idle_mem_req", 32'(mem_req), 32'd0);

      $display("[TB] single fetch, one-cycle memory wait");
      i_req = 1'b1; i_addr = 16'o1000;
      applyStimulus();
      checkOutput("f_mem_req", 32'(mem_req), 32'd1);
      checkOutput("f_owner", 32'(owner), 32'd1);
      checkOutput("f_mem_addr", 32'(mem_addr), 32'h200);
      checkOutput("f_mem_we", 32'(mem_we), 32'd0);
      applyStimulus();
      checkOutput("f_wait_mem_req", 32'(mem_req), 32'd1);
      checkOutput("f_wait_done", 32'(i_done), 32'd0);
      mem_ready = 1'b1; mem_rdata = 16'o012700;
      applyStimulus();
      checkOutput("f_i_done", 32'(i_done), 32'd1);
      checkOutput("f_i_rdata", 32'(i_rdata), 32'h15C0);
      checkOutput("f_i_err", 32'(i_err), 32'd0);
      checkOutput("f_resp_mem_req", 32'(mem_req), 32'd0);
      checkOutput("f_resp_owner", 32'(owner), 32'd1);
      checkOutput("f_d_done", 32'(d_done), 32'd0);
      i_req = 1'b0; mem_ready = 1'b0;
      applyStimulus();
      checkOutput("f_after_done", 32'(i_done), 32'd0);
      checkOutput("f_after_owner", 32'(owner), 32'd0);

      $display("[TB] byte data write to odd address");
      d_req = 1'b1; d_we = 1'b1; d_byte = 1'b1; d_addr = 16'o1001; d_wdata = 16'h00A5;
      applyStimulus();
      checkOutput("dw_mem_we", 32'(mem_we), 32'd1);
      checkOutput("dw_mem_byte", 32'(mem_byte), 32'd1);
      checkOutput("dw_mem_addr", 32'(mem_addr), 32'h201);
      checkOutput("dw_mem_wdata", 32'(mem_wdata), 32'h00A5);
      checkOutput("dw_owner", 32'(owner), 32'd2);
      mem_ready = 1'b1; mem_rdata = 16'h1234;
      applyStimulus();
      checkOutput("dw_d_done", 32'(d_done), 32'd1);
      checkOutput("dw_d_err", 32'(d_err), 32'd0);
      checkOutput("dw_d_rdata", 32'(d_rdata), 32'h1234);
      checkOutput("dw_i_done", 32'(i_done), 32'd0);
      d_req = 1'b0; d_we = 1'b0; d_byte = 1'b0; mem_ready = 1'b0;
      applyStimulus();

      $display("[TB] word fetch to odd address");
      i_req = 1'b1; i_addr = 16'o1003;
`ifdef ODD_ADDR_TRAP_EN
      applyStimulus();
      checkOutput("odd_mem_req", 32'(mem_req), 32'd0);
      checkOutput("odd_i_done", 32'(i_done), 32'd1);
      checkOutput("odd_i_err", 32'(i_err), 32'd1);
      checkOutput("odd_i_rdata", 32'(i_rdata), 32'd0);
`else
      applyStimulus();
      checkOutput("odd_mem_req", 32'(mem_req), 32'd1);
      checkOutput("odd_mem_addr", 32'(mem_addr), 32'h202);
      mem_ready = 1'b1; mem_rdata = 16'hBEEF;
      applyStimulus();
      checkOutput("odd_i_done", 32'(i_done), 32'd1);
      checkOutput("odd_i_err", 32'(i_err), 32'd0);
      checkOutput("odd_i_rdata", 32'(i_rdata), 32'hBEEF);
`endif
      i_req = 1'b0; mem_ready = 1'b0;
      applyStimulus();

      $display("[TB] both requesters held, starvation bound");
      i_req = 1'b1; i_addr = 16'h0100;
      d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = 16'h0300;
      mem_ready = 1'b1; mem_rdata = 16'h0F0F;
      for (int t = 0; t < 10; t++) begin
         expOwner = (t % 5 == 4) ? 2'b01 : 2'b10;
         applyStimulus();
         checkOutput($sformatf("arb_owner_%0d", t), 32'(owner), 32'(expOwner));
         checkOutput($sformatf("arb_addr_%0d", t), 32'(mem_addr),
                     (expOwner == 2'b01) ? 32'h100 : 32'h300);
         applyStimulus();
         checkOutput($sformatf("arb_i_done_%0d", t), 32'(i_done), 32'(expOwner == 2'b01));
         checkOutput($sformatf("arb_d_done_%0d", t), 32'(d_done), 32'(expOwner == 2'b10));
         applyStimulus();
         checkOutput($sformatf("arb_idle_owner_%0d", t), 32'(owner), 32'd0);
      end
      i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
      applyStimulus();

      $display("[TB] reset during a stalled data access");
      d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0400; d_wdata = 16'h5555;
      applyStimulus();
      checkOutput("rb_mem_req", 32'(mem_req), 32'd1);
      applyStimulus();
      applyStimulus();
      checkOutput("rb_stable_wdata", 32'(mem_wdata), 32'h5555);
      reset = 1'b1;
      applyStimulus();
      checkOutput("rb_mem_req_reset", 32'(mem_req), 32'd0);
      checkOutput("rb_owner_reset", 32'(owner), 32'd0);
      checkOutput("rb_d_done_reset", 32'(d_done), 32'd0);
      applyStimulus();
      checkOutput("rb_d_done_hold", 32'(d_done), 32'd0);
      reset = 1'b0;
      applyStimulus();
      checkOutput("rb_regrant_owner", 32'(owner), 32'd2);
      checkOutput("rb_regrant_done", 32'(d_done), 32'd0);
      mem_ready = 1'b1; mem_rdata = 16'h00C3;
      applyStimulus();
      checkOutput("rb_d_done", 32'(d_done), 32'd1);
      checkOutput("rb_d_rdata", 32'(d_rdata), 32'h00C3);
      d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
      applyStimulus();
      checkOutput("rb_final_owner", 32'(owner), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
